// File: rtl/fp_add_scheduler_pkg.sv
// Shared definitions for the FP add/sub scheduler: op encodings, format
// widths and the helpers used to size the datapath and step pointers.
`ifndef ADD
`define ADD 1'b0
`endif
`ifndef SUB
`define SUB 1'b1
`endif
`ifndef FP16
`define FP16 0
`endif
`ifndef FP32
`define FP32 1
`endif
`ifndef FP64
`define FP64 2
`endif
`ifndef FP16_W
`define FP16_W 16
`endif
`ifndef FP32_W
`define FP32_W 32
`endif
`ifndef FP64_W
`define FP64_W 64
`endif

package fp_add_scheduler_pkg;

  // Total bit width of a floating-point format selector.
  function automatic int fmt_width(input int fmt);
    case (fmt)
      `FP16:   return `FP16_W;
      `FP64:   return `FP64_W;
      default: return `FP32_W;
    endcase
  endfunction

  // Modulo-n increment used by the round-robin pointer and FIFO pointers.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/fp_sched_fifo.sv
// First-word-fall-through FIFO holding {id, data} result entries.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fp_sched_fifo
  import fp_add_scheduler_pkg::*;
#(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage array: write the tail slot on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (do_push_s) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_s) wr_q <= PW'(wrap_inc(32'(wr_q), DEPTH));
      if (do_pop_s)  rd_q <= PW'(wrap_inc(32'(rd_q), DEPTH));
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FP add/sub pipeline among
// NUM_REQ requesters. Issued ops carry their requester ID through a tag pipe
// aligned with the pipeline, and results return in issue order through a
// credit-protected FWFT FIFO.
module fp_add_scheduler
  import fp_add_scheduler_pkg::*;
#(
  parameter  int data_format = `FP32,
  parameter  int NUM_REQ     = 4,
  parameter  int ADD_LAT     = 3,
  parameter  int RES_DEPTH   = 4,
  localparam int DATA_W      = fmt_width(data_format),
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]        req_op_i,
  output logic                      add_valid_o,
  output logic [DATA_W-1:0]         add_a_o,
  output logic [DATA_W-1:0]         add_b_o,
  output logic                      add_op_o,
  input  logic                      add_res_valid_i,
  input  logic [DATA_W-1:0]         add_res_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [IDW-1:0]            rsp_id_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      err_tag_o
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int EW = IDW + DATA_W;

  logic [CW-1:0]      credits_q, credits_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     gnt_id_s;
  logic               hs_s, pop_s, push_s;
  logic               iss_valid_q, iss_op_q;
  logic [DATA_W-1:0]  iss_a_q, iss_b_q;
  logic [IDW-1:0]     iss_id_q;
  logic [ADD_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]     tag_id_q [ADD_LAT];
  logic               err_q;
  logic               fifo_full_s, fifo_empty_s;
  logic [CW-1:0]      fifo_cnt_s;
  logic [EW-1:0]      fifo_head_s;

  // Grant the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic found_v;
    int   idx_v;
    grant_s  = '0;
    gnt_id_s = '0;
    found_v  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found_v && req_valid_i[idx_v[IDW-1:0]]) begin
        found_v                  = 1'b1;
        grant_s[idx_v[IDW-1:0]]  = 1'b1;
        gnt_id_s                 = idx_v[IDW-1:0];
      end else begin
        found_v = found_v;
      end
    end
  end

  // Readiness uses the registered credit count, never a same-cycle pop.
  assign req_ready_o = (credits_q != '0) ? grant_s : '0;
  assign hs_s        = |(req_valid_i & req_ready_o);
  assign pop_s       = rsp_valid_o & rsp_ready_i;

  // Next credit count and round-robin pointer.
  always_comb begin
    credits_d = credits_q;
    rr_ptr_d  = rr_ptr_q;
    if (hs_s && !pop_s) begin
      credits_d = credits_q - CW'(1);
    end else if (!hs_s && pop_s) begin
      credits_d = credits_q + CW'(1);
    end else begin
      credits_d = credits_q;
    end
    if (hs_s) begin
      rr_ptr_d = IDW'(wrap_inc(32'(gnt_id_s), NUM_REQ));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Credit counter and arbitration pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CW'(RES_DEPTH);
      rr_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Issue register: capture the granted request; add_valid pulses one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_op_q    <= `ADD;
      iss_id_q    <= '0;
    end else begin
      iss_valid_q <= hs_s;
      if (hs_s) begin
        iss_a_q  <= req_a_i[gnt_id_s*DATA_W +: DATA_W];
        iss_b_q  <= req_b_i[gnt_id_s*DATA_W +: DATA_W];
        iss_op_q <= req_op_i[gnt_id_s];
        iss_id_q <= gnt_id_s;
      end
    end
  end

  assign add_valid_o = iss_valid_q;
  assign add_a_o     = iss_a_q;
  assign add_b_o     = iss_b_q;
  assign add_op_o    = iss_op_q;

  // Tag pipe: its last stage lines up with add_res_valid from the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int k = 0; k < ADD_LAT; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= iss_valid_q;
      tag_id_q[0]  <= iss_id_q;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign push_s = add_res_valid_i & tag_vld_q[ADD_LAT-1] & ~fifo_full_s;

  // Sticky flag for a pipeline result that has no in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (add_res_valid_i && !tag_vld_q[ADD_LAT-1]) begin
      err_q <= 1'b1;
    end
  end

  assign err_tag_o = err_q;

  fp_sched_fifo #(
    .WIDTH (EW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i ({tag_id_q[ADD_LAT-1], add_res_i}),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_cnt_s)
  );

  // An empty FIFO presents zeros rather than a stale head slot.
  assign rsp_valid_o = (fifo_cnt_s != '0);
  assign rsp_id_o    = fifo_empty_s ? '0 : fifo_head_s[EW-1 -: IDW];
  assign rsp_data_o  = fifo_empty_s ? '0 : fifo_head_s[DATA_W-1:0];

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: a behavioural FP adder stands in for the shared
// pipeline, a queue-based model predicts every cycle's outputs, and directed
// scenarios pin specific latencies, orders and credit behaviour.
module tb_fp_add_scheduler;
  localparam int NR = 4;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic          clk, rst_n;
  logic [NR-1:0] req_valid, req_ready, req_op;
  logic [NR*32-1:0] req_a, req_b;
  logic          add_valid, add_op, add_res_valid, rsp_valid, rsp_ready, err_tag;
  logic [31:0]   add_a, add_b, add_res, rsp_data;
  logic [1:0]    rsp_id;
  logic          inj;
  logic [31:0]   inj_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [1:0] id; logic [31:0] data; int rdy; } exp_t;

  logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                            32'h40800000, 32'h3FC00000, 32'h3E800000, 32'h41200000};

  fp_add_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .add_valid_o(add_valid), .add_a_o(add_a), .add_b_o(add_b), .add_op_o(add_op),
    .add_res_valid_i(add_res_valid), .add_res_i(add_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .err_tag_o(err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp_to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    ra = fp_to_real(a);
    rb = fp_to_real(b);
    return real_to_fp(op ? (ra - rb) : (ra + rb));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gidx();
    int g = -1;
    for (int k = 0; k < NR; k++) if (g < 0 && req_valid[k] && req_ready[k]) g = k;
    return g;
  endfunction

  // Stand-in adder pipeline: fixed LAT cycles, cleared by its own reset.
  logic [LAT-1:0] pv_q;
  logic [31:0]    pr_q [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int k = 0; k < LAT; k++) pr_q[k] <= '0;
    end else begin
      pv_q[0] <= add_valid;
      pr_q[0] <= fp_model(add_a, add_b, add_op);
      for (int k = 1; k < LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pr_q[k] <= pr_q[k-1];
      end
    end
  end
  assign add_res_valid = pv_q[LAT-1] | inj;
  assign add_res       = inj ? inj_data : pr_q[LAT-1];

  // Cycle-by-cycle model of the scheduler, checked at every falling edge.
  initial begin : cmp_proc
    exp_t q[$];
    exp_t e;
    int m_ptr, m_out, cyc, sel;
    logic m_prev_hs, m_err, m_pop, exp_rv, m_pop_op;
    logic [31:0] m_pa, m_pb;
    logic [NR-1:0] exp_rdy;
    m_ptr = 0; m_out = 0; cyc = 0; m_prev_hs = 1'b0; m_err = 1'b0;
    m_pa = '0; m_pb = '0; m_pop_op = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        m_ptr = 0; m_out = 0; m_prev_hs = 1'b0; m_err = 1'b0;
        check("rst_req_ready", req_ready, 0);
        check("rst_add_valid", add_valid, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_op", add_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err_tag", err_tag, 0);
      end else begin
        exp_rdy = '0;
        sel = -1;
        if (m_out < DEP) begin
          for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (sel < 0 && req_valid[j]) sel = j;
          end
        end
        if (sel >= 0) exp_rdy[sel] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("add_valid", add_valid, m_prev_hs);
        if (m_prev_hs) begin
          check("add_a", add_a, m_pa);
          check("add_b", add_b, m_pb);
          check("add_op", add_op, m_pop_op);
        end
        exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
          check("rsp_id", rsp_id, q[0].id);
          check("rsp_data", rsp_data, q[0].data);
        end
        check("err_tag", err_tag, m_err);
        m_prev_hs = (sel >= 0);
        if (sel >= 0) begin
          m_pa     = req_a[sel*32 +: 32];
          m_pb     = req_b[sel*32 +: 32];
          m_pop_op = req_op[sel];
          e.id     = 2'(sel);
          e.data   = fp_model(m_pa, m_pb, m_pop_op);
          e.rdy    = cyc + LAT + 2;
          q.push_back(e);
          m_ptr = (sel + 1) % NR;
          m_out++;
        end
        m_pop = exp_rv && rsp_ready;
        if (m_pop) begin
          void'(q.pop_front());
          m_out--;
        end
        if (inj) m_err = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int c);
    for (int r = 0; r < NR; r++) begin
      req_a[r*32 +: 32] = vals[(c + r) % 8];
      req_b[r*32 +: 32] = vals[(c * 3 + r + 1) % 8];
      req_op[r]         = 1'((c + r) % 2);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    inj       = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // Directed scenarios.
  initial begin : stim
    int n, g, lat, seen;
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1; inj = 1'b0; inj_data = 32'hDEADBEEF;
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    check("model_1p2", fp_model(32'h3F800000, 32'h40000000, 1'b0), 32'h40400000);
    check("model_4m05", fp_model(32'h40800000, 32'h3F000000, 1'b1), 32'h40600000);
    check("model_zero", fp_model(32'h3F800000, 32'h3F800000, 1'b1), 32'h00000000);

    // Single request from requester 2: 1.0 + 2.0.
    req_a[2*32 +: 32] = 32'h3F800000;
    req_b[2*32 +: 32] = 32'h40000000;
    req_op[2]         = 1'b0;
    req_valid         = 4'b0100;
    @(negedge clk);
    check("single_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("single_add_valid", add_valid, 1);
    check("single_add_a", add_a, 32'h3F800000);
    lat = -1;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid && lat < 0) begin
        lat = k;
        check("single_rsp_id", rsp_id, 2);
        check("single_rsp_data", rsp_data, 32'h40400000);
      end
    end
    check("single_latency", lat, 5);
    idle(2);

    // All requesters valid from reset: grants rotate 0,1,2,3,...
    do_reset();
    set_ops(0);
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 12; c++) begin
      @(negedge clk);
      g = gidx();
      if (g >= 0) begin
        check("rr_order", g, n % NR);
        n++;
      end
      @(posedge clk); #1;
      set_ops(c + 1);
    end
    check("rr_count", n, 12);
    req_valid = '0;
    idle(12);

    // Backpressure: exactly DEP issues, then one more per single pop.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gidx() >= 0) n++;
      @(posedge clk); #1;
    end
    check("bp_issues", n, 4);
    @(negedge clk);
    check("bp_ready_zero", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_pop_issue", gidx() >= 0, 1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (gidx() >= 0) n++;
    end
    check("post_pop_extra", n, 0);
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    idle(14);

    // Credits at 1 with a pop every cycle: issue continues every cycle.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("c1_fill", gidx(), 1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle(8);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("c1_ready", req_ready, 4'b0001);
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle(14);

    // Spurious pipeline result with nothing in flight.
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    check("spur_err", err_tag, 1);
    check("spur_no_rsp", rsp_valid, 0);
    idle(5);
    @(negedge clk);
    check("spur_err_sticky", err_tag, 1);
    @(posedge clk); #1;

    // Reset with three ops in flight.
    rsp_ready = 1'b1;
    req_valid = 4'b0111;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (gidx() >= 0) n++;
      @(posedge clk); #1;
    end
    check("mid_issued", n, 3);
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("mid_add_valid", add_valid, 0);
    check("mid_err_clear", err_tag, 0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_stale", seen, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    n = 0;
    g = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gidx() >= 0) begin
        if (n == 0) g = gidx();
        n++;
      end
      @(posedge clk); #1;
    end
    check("mid_first_grant", g, 0);
    check("mid_credits", n, 4);
    req_valid = '0;
    rsp_ready = 1'b1;
    idle(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
